// File: rtl/pipe_arbiter_pkg.sv
// Shared definitions for the pipe_arbiter slice: ID/counter sizing helpers,
// the {id, vld} tag layout carried down the tag delay line, and counter update ops.
package pipe_arbiter_pkg;

    // Tag word layout: valid flag in bit 0, requester ID directly above it.
    localparam int TAG_VLD_BIT = 0;
    localparam int TAG_ID_LSB  = 1;

    typedef enum logic [1:0] {
        CNT_HOLD = 2'd0,
        CNT_INC  = 2'd1,
        CNT_DEC  = 2'd2
    } cnt_op_e;

    function automatic int id_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int cnt_width(input int max_out);
        return $clog2(max_out + 1);
    endfunction

endpackage

// File: rtl/pipe_arbiter_tag.sv
// Multi-bit async-reset delay line; every stage shifts every clock and the
// per-stage contents are exposed so the owner can see what is in flight.
module pipe_tag #(
    parameter int WIDTH  = 4,
    parameter int LENGTH = 8
) (
    input  logic                      ck,
    input  logic                      rst_n,
    input  logic [WIDTH-1:0]          i_d,
    output logic [WIDTH-1:0]          o_q,
    output logic [LENGTH*WIDTH-1:0]   o_stages
);

    logic [WIDTH-1:0] r_stage [LENGTH];

    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < LENGTH; s++) begin
                r_stage[s] <= '0;
            end
        end else begin
            r_stage[0] <= i_d;
            for (int s = 1; s < LENGTH; s++) begin
                r_stage[s] <= r_stage[s-1];
            end
        end
    end

    assign o_q = r_stage[LENGTH-1];

    for (genvar g = 0; g < LENGTH; g++) begin : g_flat
        assign o_stages[g*WIDTH +: WIDTH] = r_stage[g];
    end

endmodule

// File: rtl/pipe_arbiter.sv
// Round-robin arbiter sharing one fixed-latency, non-stalling pipeline among N
// requesters; a tag line realigns owner IDs with results leaving the pipeline.
module pipe_arbiter
    import pipe_arbiter_pkg::*;
#(
    parameter int N       = 4,
    parameter int LENGTH  = 8,
    parameter int DATA_W  = 16,
    parameter int MAX_OUT = 4
) (
    input  logic                     ck,
    input  logic                     rst_n,
    input  logic                     enable,
    input  logic [N-1:0]             req,
    input  logic [N*DATA_W-1:0]      req_data,
    output logic [N-1:0]             gnt,
    output logic                     pipe_in_vld,
    output logic [DATA_W-1:0]        pipe_in_data,
    output logic                     rsp_vld,
    output logic [id_width(N)-1:0]   rsp_id,
    output logic                     busy
);

    localparam int IDW  = id_width(N);
    localparam int CNTW = cnt_width(MAX_OUT);
    localparam int TAGW = IDW + 1;
    localparam logic [CNTW-1:0] CNT_MAX = CNTW'(MAX_OUT);

    logic [IDW-1:0]     r_ptr;
    logic [CNTW-1:0]    r_cnt [N];
    logic               r_pipe_in_vld;
    logic [DATA_W-1:0]  r_pipe_in_data;
    logic [IDW-1:0]     r_issue_id;

    logic [N-1:0]       w_elig;
    logic [N-1:0]       w_gnt;
    logic               w_gnt_any;
    logic [IDW-1:0]     w_gnt_id;
    logic [DATA_W-1:0]  w_gnt_data;
    logic [IDW-1:0]     w_ptr_next;
    cnt_op_e            w_cnt_op [N];

    logic [TAGW-1:0]        w_tag_in;
    logic [TAGW-1:0]        w_tag_out;
    logic [LENGTH*TAGW-1:0] w_tag_stages;
    logic                   w_tag_busy;

    // Masking with rst_n keeps gnt low for the whole time reset is asserted.
    always_comb begin
        w_elig = '0;
        for (int i = 0; i < N; i++) begin
            w_elig[i] = rst_n & enable & req[i] & (r_cnt[i] < CNT_MAX);
        end
    end

    always_comb begin : rr_search
        int idx;
        idx        = 0;
        w_gnt      = '0;
        w_gnt_any  = 1'b0;
        w_gnt_id   = '0;
        w_gnt_data = '0;
        for (int off = 0; off < N; off++) begin
            idx = (int'(r_ptr) + off) % N;
            if (!w_gnt_any && w_elig[idx]) begin
                w_gnt_any   = 1'b1;
                w_gnt[idx]  = 1'b1;
                w_gnt_id    = IDW'(idx);
                w_gnt_data  = req_data[idx*DATA_W +: DATA_W];
            end
        end
    end

    assign w_ptr_next = (w_gnt_id == IDW'(N-1)) ? '0 : w_gnt_id + IDW'(1);
    assign gnt        = w_gnt;

    // r_issue_id only moves on a grant, so idle tags carry the last owner and rsp_id holds.
    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr          <= '0;
            r_pipe_in_vld  <= 1'b0;
            r_pipe_in_data <= '0;
            r_issue_id     <= '0;
        end else begin
            r_pipe_in_vld <= w_gnt_any;
            if (w_gnt_any) begin
                r_pipe_in_data <= w_gnt_data;
                r_issue_id     <= w_gnt_id;
                r_ptr          <= w_ptr_next;
            end
        end
    end

    assign pipe_in_vld  = r_pipe_in_vld;
    assign pipe_in_data = r_pipe_in_data;

    always_comb begin
        w_tag_in                         = '0;
        w_tag_in[TAG_VLD_BIT]            = r_pipe_in_vld;
        w_tag_in[TAG_ID_LSB +: IDW]      = r_issue_id;
    end

    pipe_tag #(
        .WIDTH  (TAGW),
        .LENGTH (LENGTH)
    ) u_tag (
        .ck       (ck),
        .rst_n    (rst_n),
        .i_d      (w_tag_in),
        .o_q      (w_tag_out),
        .o_stages (w_tag_stages)
    );

    assign rsp_vld = w_tag_out[TAG_VLD_BIT];
    assign rsp_id  = w_tag_out[TAG_ID_LSB +: IDW];

    always_comb begin
        w_tag_busy = 1'b0;
        for (int s = 0; s < LENGTH; s++) begin
            w_tag_busy = w_tag_busy | w_tag_stages[s*TAGW + TAG_VLD_BIT];
        end
    end

    assign busy = r_pipe_in_vld | w_tag_busy;

    // A grant and a return for the same requester in one clock cancel out.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            w_cnt_op[i] = CNT_HOLD;
            if (w_gnt[i] && !(rsp_vld && (rsp_id == IDW'(i)))) begin
                w_cnt_op[i] = CNT_INC;
            end else if (!w_gnt[i] && rsp_vld && (rsp_id == IDW'(i)) && (r_cnt[i] != '0)) begin
                w_cnt_op[i] = CNT_DEC;
            end
        end
    end

    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                unique case (w_cnt_op[i])
                    CNT_INC: r_cnt[i] <= r_cnt[i] + CNTW'(1);
                    CNT_DEC: r_cnt[i] <= r_cnt[i] - CNTW'(1);
                    default: r_cnt[i] <= r_cnt[i];
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pipe_arbiter.sv
// Self-checking bench for pipe_arbiter: table-driven grant vectors plus model-driven
// corner sequences, with a scoreboard for issue and response timing.
module tb_pipe_arbiter;

    localparam int N       = 4;
    localparam int LENGTH  = 8;
    localparam int DATA_W  = 16;
    localparam int MAX_OUT = 2;

    logic                   ck;
    logic                   rst_n;
    logic                   enable;
    logic [N-1:0]           req;
    logic [N*DATA_W-1:0]    req_data;
    logic [N-1:0]           gnt;
    logic                   pipe_in_vld;
    logic [DATA_W-1:0]      pipe_in_data;
    logic                   rsp_vld;
    logic [1:0]             rsp_id;
    logic                   busy;

    pipe_arbiter #(
        .N       (N),
        .LENGTH  (LENGTH),
        .DATA_W  (DATA_W),
        .MAX_OUT (MAX_OUT)
    ) dut (
        .ck           (ck),
        .rst_n        (rst_n),
        .enable       (enable),
        .req          (req),
        .req_data     (req_data),
        .gnt          (gnt),
        .pipe_in_vld  (pipe_in_vld),
        .pipe_in_data (pipe_in_data),
        .rsp_vld      (rsp_vld),
        .rsp_id       (rsp_id),
        .busy         (busy)
    );

    initial ck = 1'b0;
    always #5 ck = ~ck;

    typedef struct {
        int          issueCyc;
        int          rspCyc;
        int          id;
        logic [15:0] data;
    } word_t;

    typedef struct {
        logic       rstN;
        logic       en;
        logic [3:0] req;
        logic [3:0] expGnt;
    } vec_t;

    word_t       issueQ[$];
    word_t       rspQ[$];
    vec_t        vecs[$];
    int          modelPtr;
    int          modelCnt [N];
    int          pendingDec;
    logic [15:0] lastData;
    int          lastRspId;
    logic [15:0] laneData [N];
    int          cyc;
    int          nCompared;
    int          nMismatched;

    task automatic compare(input string name, input logic [31:0] act, input logic [31:0] want);
        nCompared++;
        if (act !== want) begin
            nMismatched++;
            $display("[TB] FAIL %s at cycle %0d: got %0h, want %0h", name, cyc, act, want);
        end
    endtask

    task automatic modelReset();
        issueQ.delete();
        rspQ.delete();
        modelPtr   = 0;
        for (int i = 0; i < N; i++) modelCnt[i] = 0;
        pendingDec = -1;
        lastData   = '0;
        lastRspId  = 0;
    endtask

    function automatic logic [3:0] modelGnt(input logic en, input logic [3:0] r);
        int i;
        for (int off = 0; off < N; off++) begin
            i = (modelPtr + off) % N;
            if (en && r[i] && modelCnt[i] < MAX_OUT) return 4'(1 << i);
        end
        return 4'b0;
    endfunction

    task automatic checkOutput(input logic [3:0] expGnt);
        word_t w;
        logic  expVld;
        logic  expRsp;
        logic  expBusy;
        compare("gnt", 32'(gnt), 32'(expGnt));
        expBusy = 1'b0;
        foreach (rspQ[i]) if (rspQ[i].issueCyc <= cyc) expBusy = 1'b1;
        expVld = 1'b0;
        if (issueQ.size() > 0 && issueQ[0].issueCyc == cyc) begin
            w        = issueQ.pop_front();
            expVld   = 1'b1;
            lastData = w.data;
        end
        compare("pipe_in_vld", 32'(pipe_in_vld), 32'(expVld));
        compare("pipe_in_data", 32'(pipe_in_data), 32'(lastData));
        expRsp     = 1'b0;
        pendingDec = -1;
        if (rspQ.size() > 0 && rspQ[0].rspCyc == cyc) begin
            w          = rspQ.pop_front();
            expRsp     = 1'b1;
            lastRspId  = w.id;
            pendingDec = w.id;
        end
        compare("rsp_vld", 32'(rsp_vld), 32'(expRsp));
        compare("rsp_id", 32'(rsp_id), 32'(lastRspId));
        compare("busy", 32'(busy), 32'(expBusy));
    endtask

    task automatic modelAdvance(input logic rstN, input logic [3:0] expGnt);
        word_t w;
        if (rstN) begin
            if (pendingDec >= 0) modelCnt[pendingDec]--;
            for (int k = 0; k < N; k++) begin
                if (expGnt[k]) begin
                    modelCnt[k]++;
                    modelPtr   = (k + 1) % N;
                    w.issueCyc = cyc + 1;
                    w.rspCyc   = cyc + 1 + LENGTH;
                    w.id       = k;
                    w.data     = laneData[k];
                    issueQ.push_back(w);
                    rspQ.push_back(w);
                end
            end
        end
        pendingDec = -1;
    endtask

    // Called just after a rising edge: drive, check mid-cycle, then advance the model.
    task automatic applyStimulus(input logic rstN, input logic en, input logic [3:0] r,
                                 input logic [3:0] expGnt);
        rst_n  = rstN;
        enable = en;
        req    = r;
        if (!rstN) modelReset();
        @(negedge ck);
        checkOutput(expGnt);
        @(posedge ck);
        modelAdvance(rstN, expGnt);
        cyc++;
        #1;
    endtask

    task automatic run(input logic rstN, input logic en, input logic [3:0] r, input int count);
        for (int i = 0; i < count; i++) begin
            applyStimulus(rstN, en, r, rstN ? modelGnt(en, r) : 4'b0);
        end
    endtask

    initial begin
        laneData[0] = 16'h1111;
        laneData[1] = 16'h2222;
        laneData[2] = 16'hA5A5;
        laneData[3] = 16'h4444;
        req_data    = {laneData[3], laneData[2], laneData[1], laneData[0]};
        rst_n       = 1'b0;
        enable      = 1'b0;
        req         = '0;
        nCompared   = 0;
        nMismatched = 0;
        cyc         = 0;
        modelReset();

        // Reset, release, round robin over all four, then the MAX_OUT=2 wall and refill.
        vecs.push_back('{1'b0, 1'b1, 4'hF, 4'h0});
        vecs.push_back('{1'b0, 1'b1, 4'hF, 4'h0});
        vecs.push_back('{1'b1, 1'b1, 4'hF, 4'h1});
        vecs.push_back('{1'b1, 1'b1, 4'hF, 4'h2});
        vecs.push_back('{1'b1, 1'b1, 4'hF, 4'h4});
        vecs.push_back('{1'b1, 1'b1, 4'hF, 4'h8});
        vecs.push_back('{1'b1, 1'b1, 4'hF, 4'h1});
        vecs.push_back('{1'b1, 1'b1, 4'hF, 4'h2});
        vecs.push_back('{1'b1, 1'b1, 4'hF, 4'h4});
        vecs.push_back('{1'b1, 1'b1, 4'hF, 4'h8});
        vecs.push_back('{1'b1, 1'b1, 4'hF, 4'h0});
        vecs.push_back('{1'b1, 1'b1, 4'hF, 4'h0});
        vecs.push_back('{1'b1, 1'b1, 4'hF, 4'h1});
        vecs.push_back('{1'b1, 1'b1, 4'hF, 4'h2});
        vecs.push_back('{1'b1, 1'b1, 4'hF, 4'h4});
        vecs.push_back('{1'b1, 1'b1, 4'hF, 4'h8});
        vecs.push_back('{1'b1, 1'b1, 4'h0, 4'h0});

        repeat (2) @(posedge ck);
        #1;
        $display("[TB] table vectors");
        foreach (vecs[v]) applyStimulus(vecs[v].rstN, vecs[v].en, vecs[v].req, vecs[v].expGnt);
        run(1'b1, 1'b1, 4'h0, 14);

        $display("[TB] single request latency");
        run(1'b1, 1'b1, 4'b0100, 1);
        run(1'b1, 1'b1, 4'h0, 12);

        $display("[TB] outstanding cap on requester 0");
        run(1'b1, 1'b1, 4'b0001, 14);
        run(1'b1, 1'b1, 4'h0, 12);

        $display("[TB] simultaneous grant and return on requester 1");
        run(1'b1, 1'b1, 4'b0010, 1);
        run(1'b1, 1'b1, 4'h0, 8);
        run(1'b1, 1'b1, 4'b0010, 3);
        run(1'b1, 1'b1, 4'h0, 12);

        $display("[TB] enable dropped mid-burst");
        run(1'b1, 1'b1, 4'hF, 3);
        run(1'b1, 1'b0, 4'hF, 12);
        run(1'b1, 1'b1, 4'h0, 2);

        $display("[TB] async reset mid-burst");
        run(1'b1, 1'b1, 4'hF, 5);
        run(1'b0, 1'b1, 4'hF, 1);
        run(1'b1, 1'b1, 4'h0, 12);
        run(1'b1, 1'b1, 4'hF, 1);
        run(1'b1, 1'b1, 4'h0, 12);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
